// File: rtl/dilithium_io_pkg.sv
// Shared types and constants for the Dilithium core's 64-bit input path.
package dilithium_io_pkg;

  localparam int WORD_W      = 64;
  localparam int COUNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } framer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// DEPTH x 64-bit synchronous FIFO with flush; read data is the registered head entry.
module sync_fifo
  import dilithium_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              pop,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments only; the storage
  // array is reset too so the head word reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/dilithium_input_framer.sv
// Frames the host word stream into start-bounded operations toward the core,
// buffering words in a small FIFO and flagging protocol errors.
module dilithium_input_framer
  import dilithium_io_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  output logic               valid_i,
  input  logic               ready_i,
  output logic [WORD_W-1:0]  data_i,
  output logic               frame_active,
  output logic               done,
  output logic [COUNT_W-1:0] word_count,
  output logic               err_start,
  output logic               err_stray
);

  framer_state_t      state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_start_q, err_start_d;
  logic               err_stray_q, err_stray_d;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  // Abort wins over any transfer in the same cycle.
  assign s_ready      = (state_q == ACTIVE) && !fifo_full;
  assign valid_i      = !fifo_empty;
  assign push         = s_valid && s_ready && !abort;
  assign pop          = valid_i && ready_i && !abort;
  assign frame_active = (state_q != IDLE);
  assign word_count   = count_q;
  assign err_start    = err_start_q;
  assign err_stray    = err_stray_q;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (abort),
    .push    (push),
    .wr_data (s_data),
    .pop     (pop),
    .rd_data (data_i),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    done        = 1'b0;
    err_start_d = err_start_q | (start && (state_q != IDLE));
    err_stray_d = err_stray_q | (s_valid && (state_q == IDLE));

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACTIVE;
            count_d = '0;
          end
        end
        ACTIVE: begin
          if (push) begin
            if (count_q != '1) count_d = count_q + COUNT_W'(1);
            if (s_last) state_d = DRAIN;
          end
        end
        DRAIN: begin
          // An empty FIFO implies valid_i=0, so no pop can be in flight.
          if (fifo_empty) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      err_start_q <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_start_q <= err_start_d;
      err_stray_q <= err_stray_d;
    end
  end

endmodule

// File: tb/tb_dilithium_input_framer.sv
// Directed bench for dilithium_input_framer: a vector table for the basic frame
// plus hand-written sequences for backpressure, errors, abort and reset.
module tb_dilithium_input_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, ready_i = 1'b1;
  logic [63:0] s_data = '0;
  logic        s_ready, valid_i, frame_active, done, err_start, err_stray;
  logic [63:0] data_i;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dilithium_input_framer #(.DEPTH(4), .COUNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .valid_i      (valid_i),
    .ready_i      (ready_i),
    .data_i       (data_i),
    .frame_active (frame_active),
    .done         (done),
    .word_count   (word_count),
    .err_start    (err_start),
    .err_stray    (err_stray)
  );

  typedef struct {
    logic        start;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_last;
    logic        ready_i;
    logic        exp_s_ready;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_done;
    logic        exp_active;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic st, logic sv, logic [63:0] sd, logic sl, logic rdy,
                              logic e_rdy, logic e_v, logic [63:0] e_d, logic e_done,
                              logic e_act, logic [15:0] e_cnt);
    vec_t v;
    v.start = st; v.s_valid = sv; v.s_data = sd; v.s_last = sl; v.ready_i = rdy;
    v.exp_s_ready = e_rdy; v.exp_valid = e_v; v.exp_data = e_d; v.exp_done = e_done;
    v.exp_active = e_act; v.exp_count = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},      s_ready,      0);
    check({tag, "_valid_i"},      valid_i,      0);
    check({tag, "_data_i"},       data_i,       0);
    check({tag, "_frame_active"}, frame_active, 0);
    check({tag, "_done"},         done,         0);
    check({tag, "_word_count"},   word_count,   0);
    check({tag, "_err_start"},    err_start,    0);
    check({tag, "_err_stray"},    err_stray,    0);
  endtask

  // Starts a frame of n words base..base+n-1, streams it through a scoreboard,
  // and checks ordering, stall stability, done timing and the final count.
  task automatic run_frame(input logic [63:0] base, input int n, input int stall_from,
                           input int stall_len, input int restart_at, input int exp_block);
    int          idx = 0, rcv = 0, done_cnt = 0, cyc = 0, last_pop = -10, block_at = -1;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [63:0] q [$];
    @(posedge clk); #1;
    start = 1'b1; s_valid = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && cyc < 300) begin
      s_valid = (idx < n);
      s_data  = base + 64'(idx);
      s_last  = (idx == n - 1);
      ready_i = !(cyc >= stall_from && cyc < stall_from + stall_len);
      start   = (cyc == restart_at);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_after_last_pop", 64'(cyc), 64'(last_pop + 1));
        check("done_all_words", 64'(rcv), 64'(n));
      end
      if (prev_stall && valid_i) check("stall_data_hold", data_i, prev_data);
      if (block_at < 0 && s_valid && !s_ready) block_at = idx;
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        idx++;
      end
      if (valid_i && ready_i) begin
        check("pop_has_expected", 64'(q.size() > 0), 1);
        if (q.size() > 0) check("core_word", data_i, q.pop_front());
        rcv++;
        last_pop = cyc;
      end
      prev_stall = valid_i && !ready_i;
      prev_data  = data_i;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0; ready_i = 1'b1;
    check("frame_done_seen", 64'(done_cnt), 1);
    check("frame_word_count", word_count, 64'(n));
    if (exp_block >= 0) check("block_after_accepts", 64'(block_at), 64'(exp_block));
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("single_done", 64'(done_cnt), 1);
    check("idle_after_frame", frame_active, 0);
  endtask

  initial begin
    int done_seen;

    // Five-word frame 1..5 with the core always ready.
    vecs[0] = mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    vecs[1] = mk(0, 1, 1, 0, 1,  1, 0, 0, 0, 1, 0);
    vecs[2] = mk(0, 1, 2, 0, 1,  1, 1, 1, 0, 1, 1);
    vecs[3] = mk(0, 1, 3, 0, 1,  1, 1, 2, 0, 1, 2);
    vecs[4] = mk(0, 1, 4, 0, 1,  1, 1, 3, 0, 1, 3);
    vecs[5] = mk(0, 1, 5, 1, 1,  1, 1, 4, 0, 1, 4);
    vecs[6] = mk(0, 0, 0, 0, 1,  0, 1, 5, 0, 1, 5);
    vecs[7] = mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 5);
    vecs[8] = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 5);

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      start = vecs[i].start; s_valid = vecs[i].s_valid; s_data = vecs[i].s_data;
      s_last = vecs[i].s_last; ready_i = vecs[i].ready_i;
      @(negedge clk);
      check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_s_ready);
      check($sformatf("vec%0d_valid_i", i), valid_i, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data_i", i), data_i, vecs[i].exp_data);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d_frame_active", i), frame_active, vecs[i].exp_active);
      check($sformatf("vec%0d_word_count", i), word_count, vecs[i].exp_count);
    end
    check("no_err_start_yet", err_start, 0);
    check("no_err_stray_yet", err_stray, 0);

    // 8-word frame with a 10-cycle core stall: upstream blocks once 4 are queued.
    run_frame(64'h10, 8, 0, 10, -1, 4);

    // Stray word before start.
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 64'hDEAD;
    repeat (2) begin
      @(negedge clk);
      check("stray_s_ready", s_ready, 0);
      check("stray_valid_i", valid_i, 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("stray_err", err_stray, 1);
    check("stray_no_word", valid_i, 0);
    run_frame(64'h100, 3, 0, 0, -1, -1);

    // Second start while ACTIVE: flagged, count not cleared.
    check("err_start_before", err_start, 0);
    run_frame(64'h300, 4, 0, 0, 2, -1);
    check("err_start_after", err_start, 1);

    // Abort after 3 of 6 words with 2 still queued.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 64'hA1; ready_i = 1'b0;
    @(negedge clk);
    check("abort_s_ready_open", s_ready, 1);
    @(posedge clk); #1;
    s_data = 64'hA2;
    @(posedge clk); #1;
    s_data = 64'hA3; ready_i = 1'b1;
    @(posedge clk); #1;
    s_data = 64'hA4; ready_i = 1'b0; abort = 1'b1;
    @(negedge clk);
    check("abort_pre_valid", valid_i, 1);
    check("abort_pre_head", data_i, 64'hA2);
    check("abort_pre_count", word_count, 3);
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0; ready_i = 1'b1;
    done_seen = 0;
    @(negedge clk);
    check("abort_valid_i", valid_i, 0);
    check("abort_frame_active", frame_active, 0);
    check("abort_s_ready", s_ready, 0);
    check("abort_word_count", word_count, 3);
    repeat (3) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_seen), 0);

    // Reset asserted mid-DRAIN.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = 64'hB1; ready_i = 1'b0;
    @(posedge clk); #1;
    s_data = 64'hB2; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("drain_active", frame_active, 1);
    check("drain_s_ready", s_ready, 0);
    check("drain_valid", valid_i, 1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("mid_drain_reset");
    @(posedge clk); #1;
    rst = 1'b1; ready_i = 1'b1;
    run_frame(64'h200, 1, 0, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
